// File: rtl/lamp_sequence_monitor.sv
// lamp_sequence_monitor
//   Run-time checker for a cyclic R->G->Y lamp controller. Samples the lamp
//   code on every enabled clock edge and checks three things: the code is
//   one-hot, colour changes follow R->G->Y->R, and each colour persists for
//   MIN_DWELL..MAX_DWELL samples. Faults are sticky until clr_fault.
//
// Ports
//   clk          rising-edge clock (shared with the lamp controller)
//   rst_n        asynchronous active-low reset
//   en           sample enable; 0 holds every register
//   light[0:2]   lamp code: [0]=Red, [1]=Green, [2]=Yellow
//   clr_fault    synchronous clear of the sticky flags (needs en=1)
//   locked       tracking a legal colour
//   cur_color    0=none, 1=R, 2=G, 3=Y
//   illegal_code sticky: sampled code was not one-hot
//   order_err    sticky: colour change was not the legal successor
//   dwell_err    sticky: colour held too briefly or too long
//   fault        OR of the sticky flags
//   cycle_count  legal Y->R transitions, saturating at all-ones
module lamp_sequence_monitor #(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [0:2]       light,
    input  logic             clr_fault,
    output logic             locked,
    output logic [1:0]       cur_color,
    output logic             illegal_code,
    output logic             order_err,
    output logic             dwell_err,
    output logic             fault,
    output logic [CNT_W-1:0] cycle_count
);

    // Dwell counter must hold MAX_DWELL+1 (the saturated "too long" value).
    localparam int            DW   = $clog2(MAX_DWELL + 2);
    localparam logic [DW-1:0] DMIN = DW'(MIN_DWELL);
    localparam logic [DW-1:0] DMAX = DW'(MAX_DWELL);
    localparam logic [DW-1:0] DSAT = DW'(MAX_DWELL + 1);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t             state, state_nxt;
    logic [1:0]         color_nxt;
    logic [DW-1:0]      dwell, dwell_nxt;
    logic               ill_nxt, ord_nxt, dw_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [1:0]         code;
    logic [1:0]         succ;

    // One-hot decode; anything else maps to 0 (illegal).
    always_comb begin
        code = 2'd0;
        case (light)
            3'b100:  code = 2'd1;
            3'b010:  code = 2'd2;
            3'b001:  code = 2'd3;
            default: code = 2'd0;
        endcase
    end

    assign succ = (cur_color == 2'd3) ? 2'd1 : cur_color + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= UNLOCKED;
            cur_color    <= 2'd0;
            dwell        <= '0;
            illegal_code <= 1'b0;
            order_err    <= 1'b0;
            dwell_err    <= 1'b0;
            cycle_count  <= '0;
        end else begin
            state        <= state_nxt;
            cur_color    <= color_nxt;
            dwell        <= dwell_nxt;
            illegal_code <= ill_nxt;
            order_err    <= ord_nxt;
            dwell_err    <= dw_nxt;
            cycle_count  <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        color_nxt = cur_color;
        dwell_nxt = dwell;
        ill_nxt   = illegal_code;
        ord_nxt   = order_err;
        dw_nxt    = dwell_err;
        cnt_nxt   = cycle_count;

        if (en) begin
            // Clear first so that any error detected on this edge wins.
            if (clr_fault) begin
                ill_nxt = 1'b0;
                ord_nxt = 1'b0;
                dw_nxt  = 1'b0;
            end

            if (state == UNLOCKED) begin
                // Lock edge: no order or dwell check, history is unknown.
                if (code != 2'd0) begin
                    state_nxt = LOCKED;
                    color_nxt = code;
                    dwell_nxt = DW'(1);
                end else begin
                    ill_nxt = 1'b1;
                end
            end else begin
                if (code == 2'd0) begin
                    ill_nxt   = 1'b1;
                    state_nxt = UNLOCKED;
                    color_nxt = 2'd0;
                    dwell_nxt = '0;
                end else if (code == cur_color) begin
                    // Flag only on the crossing; counter parks at DSAT.
                    if (dwell == DMAX) begin
                        dwell_nxt = DSAT;
                        dw_nxt    = 1'b1;
                    end else if (dwell < DMAX) begin
                        dwell_nxt = dwell + DW'(1);
                    end
                end else begin
                    if (dwell < DMIN)
                        dw_nxt = 1'b1;
                    if (code != succ)
                        ord_nxt = 1'b1;
                    // Y->R is always the legal successor; dwell errors do not block it.
                    if (cur_color == 2'd3 && code == 2'd1 &&
                        cycle_count != {CNT_W{1'b1}})
                        cnt_nxt = cycle_count + CNT_W'(1);
                    color_nxt = code;
                    dwell_nxt = DW'(1);
                end
            end
        end
    end

    assign locked = (state == LOCKED);
    assign fault  = illegal_code | order_err | dwell_err;

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
module tb_lamp_sequence_monitor;

    localparam logic [0:2] R   = 3'b100;
    localparam logic [0:2] G   = 3'b010;
    localparam logic [0:2] Y   = 3'b001;
    localparam logic [0:2] GY  = 3'b011;
    localparam logic [0:2] OFF = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [0:2] light = 3'b000;
    logic       clr_fault = 1'b0;

    // d0: defaults, d1: MIN_DWELL=2, d2: CNT_W=2. All share the stimulus.
    logic       lk0, lk1, lk2, il0, il1, il2, or0, or1, or2, dw0, dw1, dw2, f0, f1, f2;
    logic [1:0] cc0, cc1, cc2;
    logic [7:0] cn0, cn1;
    logic [1:0] cn2;

    lamp_sequence_monitor d0 (.clk(clk), .rst_n(rst_n), .en(en), .light(light), .clr_fault(clr_fault),
        .locked(lk0), .cur_color(cc0), .illegal_code(il0), .order_err(or0), .dwell_err(dw0),
        .fault(f0), .cycle_count(cn0));
    lamp_sequence_monitor #(.MIN_DWELL(2)) d1 (.clk(clk), .rst_n(rst_n), .en(en), .light(light),
        .clr_fault(clr_fault), .locked(lk1), .cur_color(cc1), .illegal_code(il1), .order_err(or1),
        .dwell_err(dw1), .fault(f1), .cycle_count(cn1));
    lamp_sequence_monitor #(.CNT_W(2)) d2 (.clk(clk), .rst_n(rst_n), .en(en), .light(light),
        .clr_fault(clr_fault), .locked(lk2), .cur_color(cc2), .illegal_code(il2), .order_err(or2),
        .dwell_err(dw2), .fault(f2), .cycle_count(cn2));

    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic [14:0] v;
        string      name;
    } exp_t;

    exp_t q[$];
    int   sel = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // {locked, cur_color, illegal, order, dwell, fault, cycle_count[7:0]}
    function automatic logic [14:0] actual(input int s);
        case (s)
            0:       return {lk0, cc0, il0, or0, dw0, f0, cn0};
            1:       return {lk1, cc1, il1, or1, dw1, f1, cn1};
            default: return {lk2, cc2, il2, or2, dw2, f2, 6'd0, cn2};
        endcase
    endfunction

    function automatic logic [14:0] pack(input logic l, input logic [1:0] c, input logic i,
                                         input logic o, input logic d, input logic [7:0] n);
        return {l, c, i, o, d, i | o | d, n};
    endfunction

    task automatic check(input string nm, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got lk=%0b col=%0d ill=%0b ord=%0b dw=%0b flt=%0b cnt=%0d, expected lk=%0b col=%0d ill=%0b ord=%0b dw=%0b flt=%0b cnt=%0d",
                     nm, act[14], act[13:12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[14], exp[13:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // Monitor: every clock edge that has a pending expectation is checked.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.name, actual(e.sel), e.v);
        end
    end

    task automatic step(input logic e, input logic [0:2] l, input logic c,
                        input logic xl, input logic [1:0] xc, input logic xi, input logic xo,
                        input logic xd, input logic [7:0] xn, input string nm);
        exp_t x;
        en = e; light = l; clr_fault = c;
        x.sel = sel; x.v = pack(xl, xc, xi, xo, xd, xn); x.name = nm;
        q.push_back(x);
        @(negedge clk);
    endtask

    // Asynchronous reset applied between edges, checked before any edge.
    task automatic do_reset(input string nm);
        en = 1'b0; clr_fault = 1'b0;
        #2 rst_n = 1'b0;
        #1 check(nm, actual(sel), 15'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset("reset_defaults");

        // 1: clean sequence, two completed cycles after the 9th edge
        step(1, R, 0, 1, 1, 0, 0, 0, 0, "seq_r1");
        step(1, G, 0, 1, 2, 0, 0, 0, 0, "seq_g1");
        step(1, Y, 0, 1, 3, 0, 0, 0, 0, "seq_y1");
        step(1, R, 0, 1, 1, 0, 0, 0, 1, "seq_r2");
        step(1, G, 0, 1, 2, 0, 0, 0, 1, "seq_g2");
        step(1, Y, 0, 1, 3, 0, 0, 0, 1, "seq_y2");
        step(1, R, 0, 1, 1, 0, 0, 0, 2, "seq_r3");
        step(1, G, 0, 1, 2, 0, 0, 0, 2, "seq_g3");
        step(1, Y, 0, 1, 3, 0, 0, 0, 2, "seq_y3");

        // 2: illegal code unlocks, relock without order check, clear
        step(1, GY, 0, 0, 0, 1, 0, 0, 2, "illegal_011");
        step(1, R,  0, 1, 1, 1, 0, 0, 2, "relock_r");
        step(1, R,  1, 1, 1, 0, 0, 0, 2, "clr_illegal");

        // 3: R->Y order error, then legal Y->R counts
        step(1, Y, 0, 1, 3, 0, 1, 0, 2, "order_r_to_y");
        step(1, R, 0, 1, 1, 0, 1, 0, 3, "y_to_r_counts");
        step(1, R, 1, 1, 1, 0, 0, 0, 3, "clr_order");

        // 4: G dwell of 8 is fine, 9th sample trips dwell_err
        for (int i = 1; i <= 8; i++)
            step(1, G, 0, 1, 2, 0, 0, 0, 3, $sformatf("dwell_g%0d", i));
        step(1, G, 0, 1, 2, 0, 0, 1, 3, "dwell_g9_over");

        // 5a: error wins over clr_fault on the same edge
        step(1, OFF, 1, 0, 0, 1, 0, 0, 3, "clr_vs_illegal_000");

        // 5b: en=0 freezes everything, including clr_fault
        step(0, R,  1, 0, 0, 1, 0, 0, 3, "frozen_1");
        step(0, G,  0, 0, 0, 1, 0, 0, 3, "frozen_2");
        step(0, Y,  1, 0, 0, 1, 0, 0, 3, "frozen_3");
        step(0, GY, 0, 0, 0, 1, 0, 0, 3, "frozen_4");
        step(0, R,  0, 0, 0, 1, 0, 0, 3, "frozen_5");
        step(1, R,  0, 1, 1, 1, 0, 0, 3, "unfreeze_r");

        // 5c: async reset mid-dwell, then relock on G without order check
        do_reset("async_reset_mid");
        step(1, G, 0, 1, 2, 0, 0, 0, 0, "post_reset_g");
        step(1, Y, 0, 1, 3, 0, 0, 0, 0, "post_reset_y");

        // 4b: MIN_DWELL=2 instance
        sel = 1;
        do_reset("reset_min2");
        step(1, R, 0, 1, 1, 0, 0, 0, 0, "min2_r");
        step(1, G, 0, 1, 2, 0, 0, 1, 0, "min2_short_r");
        do_reset("reset_min2_b");
        step(1, R, 0, 1, 1, 0, 0, 0, 0, "min2_r_a");
        step(1, R, 0, 1, 1, 0, 0, 0, 0, "min2_r_b");
        step(1, G, 0, 1, 2, 0, 0, 0, 0, "min2_ok_g");

        // 6: CNT_W=2 saturates at 3
        sel = 2;
        do_reset("reset_cnt2");
        step(1, R, 0, 1, 1, 0, 0, 0, 0, "cnt2_start");
        for (int k = 1; k <= 5; k++) begin
            step(1, G, 0, 1, 2, 0, 0, 0, 8'((k > 3 ? 3 : k - 1)), $sformatf("cnt2_g%0d", k));
            step(1, Y, 0, 1, 3, 0, 0, 0, 8'((k > 3 ? 3 : k - 1)), $sformatf("cnt2_y%0d", k));
            step(1, R, 0, 1, 1, 0, 0, 0, 8'((k > 3 ? 3 : k)),     $sformatf("cnt2_r%0d", k));
        end

        en = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lamp_sequence_monitor.md
Name: lamp_sequence_monitor

Overview:
Downstream checker for the cyclic RGY lamp controller. Samples the 3-bit lamp code every clock and checks it.
- Code legality: exactly one lamp lit.
- Sequence order: R->G->Y->R.
- Per-colour dwell time: within [MIN_DWELL, MAX_DWELL].
Reports sticky fault flags, the decoded current colour and a count of completed cycles. Sits beside or after the lamp controller, in system or bench, as a run-time safety monitor.

Parameters:
MIN_DWELL, 1, minimum consecutive samples a colour must persist before changing (>=1)
MAX_DWELL, 8, maximum consecutive samples a colour may persist (>=MIN_DWELL)
CNT_W, 8, width of cycle_count

Ports:
clk  input  1  rising-edge clock, same clock as the lamp controller
rst_n  input  1  asynchronous active-low reset
en  input  1  sample enable; 0 = hold all state and outputs
light  input  [0:2]  lamp code; light[0]=Red, light[1]=Green, light[2]=Yellow
clr_fault  input  1  synchronous clear of sticky fault flags
locked  output  1  monitor is tracking a legal colour
cur_color  output  2  0=none, 1=R, 2=G, 3=Y (last legal sample while locked)
illegal_code  output  1  sticky: sampled code not one-hot (000, 011, 101, 110, 111)
order_err  output  1  sticky: colour change not R->G, G->Y or Y->R
dwell_err  output  1  sticky: dwell below MIN_DWELL at change, or above MAX_DWELL
fault  output  1  OR of the three sticky flags (combinational from registers)
cycle_count  output  CNT_W  number of legal Y->R transitions, saturating at all-ones

Behaviour:
- All outputs are registered, except `fault`. Each event is evaluated on the rising edge that samples `light` and is visible right after that edge (zero-cycle latency relative to the sampling edge).
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=UNLOCKED, locked=0, cur_color=0.
  - All flags=0, cycle_count=0.
  - Internal dwell counter=0 and prev_color=0.
- en=0: no state, flag or counter changes, including clr_fault.
- State UNLOCKED, per enabled edge:
  - Legal code: -> LOCKED, prev_color/cur_color=code, dwell=1. No order or dwell check on the lock edge.
  - Illegal code: illegal_code<=1, stay UNLOCKED.
- State LOCKED, per enabled edge:
  - Illegal code: illegal_code<=1, -> UNLOCKED, cur_color=0, dwell=0.
  - Same colour as prev: dwell<=dwell+1, saturating at MAX_DWELL+1. When dwell goes from MAX_DWELL to MAX_DWELL+1, dwell_err<=1.
  - Different legal colour:
    - If dwell<MIN_DWELL, dwell_err<=1.
    - If not the legal successor, order_err<=1.
    - In all cases: resync with prev_color/cur_color=new code, dwell=1, stay LOCKED.
    - Only a legal Y->R transition increments cycle_count, and only if it saturates below all-ones. A Y->R with dwell_err still counts.
- Dwell counter width: ceil(log2(MAX_DWELL+2)) bits.
- clr_fault=1 with en=1 clears all three flags on that edge. If a new error is detected on the same edge, the error wins: that flag is set, others clear.
- Flags never clear on their own. `locked` and `cycle_count` are unaffected by clr_fault.
- Reset asserted mid-cycle or mid-dwell discards all history. First legal sample after reset relocks with no order check.

Test Plan:
1. Reset, en=1, defaults. Drive R,G,Y,R,G,Y,R,G,Y, one per clock -> locked=1 from the 1st edge; cur_color follows 1,2,3,...; no flags; cycle_count=2 after the 9th edge.
2. Inject light=3'b011 while locked -> illegal_code=1, locked=0, cur_color=0 that edge. Next R -> locked=1, illegal_code still 1. Pulse clr_fault -> fault=0.
3. Locked on R, drive Y -> order_err=1, cur_color=3, cycle_count unchanged. Then R -> cycle_count+1 (legal Y->R).
4. Dwell: hold G for 8 samples -> dwell_err=0; 9th sample G -> dwell_err=1. Instance with MIN_DWELL=2: R for 1 sample then G -> dwell_err=1.
5. Simultaneous events:
   - clr_fault=1 on the same edge as an illegal 000 -> illegal_code=1, other flags 0.
   - en=0 for 5 cycles with changing light -> all outputs frozen.
   - rst_n pulsed low between edges -> outputs 0 immediately, without waiting for a clock edge.
6. CNT_W=2 instance: 5 complete R->G->Y->R cycles -> cycle_count=3 (saturated), no wrap.
